// File: rtl/fir_pkg.sv
// Shared types and helpers for the sequential I2S FIR stage.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_t;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  function automatic int unsigned fir_acc_w(input int unsigned ntaps);
    return 33 + $clog2(ntaps);
  endfunction

  // |v| as a 16-bit magnitude; -32768 maps to 0x8000.
  function automatic logic [15:0] sm_mag(input logic signed [15:0] v);
    return v[15] ? 16'(-v) : 16'(v);
  endfunction

endpackage

// File: rtl/signed_mult.sv
// 16x16 unsigned multiplier shared by the FIR MAC loop; purely combinational.
module signed_mult (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  assign p = 32'(a) * 32'(b);

endmodule

// File: rtl/i2s_fir_mac.sv
// NTAPS-tap FIR over 16-bit PCM, one tap per cycle through a shared unsigned
// multiplier, with round-half-up and saturation to 16 bits.
module i2s_fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS     = 8,
  parameter int unsigned COEF_FRAC = 15,
  parameter int unsigned ACC_W     = fir_acc_w(NTAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_data,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [15:0]              coef_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data
);

  localparam int unsigned      AW   = $clog2(NTAPS);
  localparam logic [AW-1:0]    LAST = AW'(NTAPS - 1);
  localparam logic [ACC_W-1:0] HALF = ACC_W'(2 ** (COEF_FRAC - 1));

  state_t state, state_nxt;

  logic signed [15:0]      x_dly  [NTAPS];
  logic signed [15:0]      h_coef [NTAPS];
  logic [AW-1:0]           tap;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;

  logic [15:0]             ma;
  logic [15:0]             mb;
  logic [31:0]             prod;
  logic                    neg;
  logic signed [ACC_W-1:0] pext;

  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shf;
  logic [ACC_W-16:0]       upper;
  logic [15:0]             sat;

  logic accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Sign-magnitude around the unsigned multiplier: sign restored on accumulate.
  always_comb begin
    ma   = sm_mag(x_dly[tap]);
    mb   = sm_mag(h_coef[tap]);
    neg  = x_dly[tap][15] ^ h_coef[tap][15];
    pext = {{(ACC_W - 32){1'b0}}, prod};
    acc_nxt = neg ? (acc - pext) : (acc + pext);
  end

  signed_mult u_mult (
    .a (ma),
    .b (mb),
    .p (prod)
  );

  // Arithmetic shift floors, so adding half first rounds ties toward +inf.
  always_comb begin
    rnd   = acc + $signed(HALF);
    shf   = rnd >>> COEF_FRAC;
    upper = shf[ACC_W-1:15];
    if ((&upper) || !(|upper)) begin
      sat = shf[15:0];
    end else if (shf[ACC_W-1]) begin
      sat = SAT_MIN;
    end else begin
      sat = SAT_MAX;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (tap == LAST) state_nxt = ROUND;
      ROUND:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      tap       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        x_dly[i]  <= '0;
        h_coef[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (coef_we) h_coef[coef_addr] <= coef_wdata;
          if (accept) begin
            for (int unsigned i = NTAPS - 1; i > 0; i--) x_dly[i] <= x_dly[i-1];
            x_dly[0] <= in_data;
            acc      <= '0;
            tap      <= '0;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          tap <= tap + 1'b1;
        end
        ROUND: begin
          out_data  <= sat;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_fir_mac.sv
// Scoreboard bench for i2s_fir_mac: directed samples push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_i2s_fir_mac;

  localparam int NTAPS = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [15:0] in_data;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic [15:0]       coef_wdata;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] out_data;

  int n_cmp = 0;
  int n_err = 0;
  logic signed [15:0] exp_q[$];
  logic signed [15:0] mon_exp;

  always #5 clk = ~clk;

  i2s_fir_mac #(.NTAPS(NTAPS), .COEF_FRAC(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_out: got %0d, expected no output", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", int'(out_data), int'(mon_exp));
      end
    end
  end

  task automatic wcoef(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = 3'(addr);
    coef_wdata = 16'(val);
    @(posedge clk); #1;
    coef_we    = 1'b0;
  endtask

  task automatic set_all(input int val);
    for (int k = 0; k < NTAPS; k++) wcoef(k, val);
  endtask

  task automatic run(input int x, input int expv, input int hold = 0,
                     input bit mac_wr = 0, input bit acc_wr = 0, input int wval = 0);
    int lat;
    bit rdy_bad;
    bit stable;
    logic signed [15:0] held;
    out_ready = (hold == 0);
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    check("in_ready_idle", int'(in_ready), 1);
    exp_q.push_back(16'(expv));
    in_valid = 1'b1;
    in_data  = 16'(x);
    if (acc_wr) begin
      coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'(wval);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    lat = 1;
    rdy_bad = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) rdy_bad = 1;
      if (mac_wr && lat == 2) begin
        coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'(wval);
      end else begin
        coef_we = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    coef_we = 1'b0;
    check("latency", lat, NTAPS + 2);
    check("in_ready_busy", int'(rdy_bad), 0);
    if (hold > 0) begin
      held = out_data;
      stable = 1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (out_data !== held || !out_valid || in_ready) stable = 0;
      end
      check("hold_stable", int'(stable), 1);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("idle_after_hs", int'({out_valid, in_ready}), 1);
  endtask

  int imp_exp [NTAPS];
  int pos_exp [NTAPS] = '{32766, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
  int neg_exp [NTAPS] = '{32767, 32767, 32767, -4, -32768, -32768, -32768, -32768};
  bit ov_seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
    coef_addr = '0; coef_wdata = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    rst = 1'b0;

    wcoef(0, 16'h4000);
    run(1000, 500);
    run(-3, -1);
    run(3, 2);
    repeat (NTAPS) run(0, 0);

    // 8<<12 wraps to 0x8000 = -1.0, so the last impulse tap comes out negative.
    for (int k = 0; k < NTAPS; k++) begin
      wcoef(k, (k + 1) << 12);
      imp_exp[k] = (k == 7) ? -4096 : 512 * (k + 1);
    end
    run(4096, imp_exp[0]);
    for (int k = 1; k < NTAPS; k++) run(0, imp_exp[k]);

    set_all(16'h7FFF);
    for (int k = 0; k < NTAPS; k++) run(32767, pos_exp[k]);
    for (int k = 0; k < NTAPS; k++) run(-32768, neg_exp[k]);

    wcoef(0, 16'h8000);
    for (int k = 1; k < NTAPS; k++) wcoef(k, 0);
    run(-32768, 32767);

    wcoef(0, 16'h4000);
    run(1000, 500, 20, 1'b1, 1'b0, 16'h7FFF);
    run(1000, 500);
    run(1000, 250, 0, 1'b0, 1'b1, 16'h2000);

    in_valid = 1'b1; in_data = 16'sd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ov_seen = out_valid;
    @(posedge clk); #1;
    ov_seen |= out_valid;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin
      ov_seen |= out_valid;
      @(posedge clk); #1;
    end
    check("no_out_after_rst", int'(ov_seen), 0);
    run(1000, 0);
    set_all(16'h4000);
    run(0, 500);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
